hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage core.
- Generates the execute-stage forwarding selects, load-use stalls, control-hazard flushes, and multi-cycle MDU (mul/div) occupancy stalls.
- Keeps saturating stall/flush performance counters.
- Sits beside the datapath; outputs drive the stage-register enables/clears and the execute forwarding muxes.

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: execute-stage
// forwarding selects, load-use stalls, branch flushes, MDU occupancy stalls
// and saturating stall/flush performance counters.
`timescale 1ns/1ps
module hazard_ctrl #(
   parameter int MDU_LATENCY = 4,   // total cycles an MDU op holds execute (2..16)
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           rs1_d,
   input  logic [4:0]           rs2_d,
   input  logic [4:0]           rs1_e,
   input  logic [4:0]           rs2_e,
   input  logic [4:0]           rd_e,
   input  logic [1:0]           res_src_e,
   input  logic                 mdu_op_e,
   input  logic                 pc_src_e,
   input  logic [4:0]           rd_m,
   input  logic                 reg_write_m,
   input  logic [4:0]           rd_w,
   input  logic                 reg_write_w,
   output logic [1:0]           forward_a_e,
   output logic [1:0]           forward_b_e,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_m,
   output logic                 mdu_busy,
   output logic                 mdu_done,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // The first execute cycle is spent in IDLE, the last one is the done
   // cycle, so BUSY counts down from MDU_LATENCY-2 to 0.
   localparam logic [3:0] CNT_INIT = 4'(MDU_LATENCY - 2);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       mdu_stall, mdu_done_raw, mdu_busy_raw;
   logic       lw_stall;
   logic [1:0] fwd_a, fwd_b;

   // M-stage result wins over W-stage; x0 never forwards
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdm, input logic rwm,
                                          input logic [4:0] rdw, input logic rww);
      if (rs == 5'd0)               return 2'b00;
      else if (rwm && (rdm == rs))  return 2'b01;
      else if (rww && (rdw == rs))  return 2'b10;
      else                          return 2'b00;
   endfunction

   // Forwarding selects and load-use detection
   always_comb begin
      fwd_a    = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      fwd_b    = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      lw_stall = (res_src_e == 2'b01) && (rd_e != 5'd0) &&
                 ((rd_e == rs1_d) || (rd_e == rs2_d));
   end

   // MDU FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // MDU FSM next state; branch redirects do not disturb an op in flight
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (mdu_op_e) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
         end
         BUSY: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
               else             state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // MDU FSM outputs; the done cycle releases execute so a following op
   // can be accepted from IDLE on the very next cycle
   always_comb begin
      mdu_stall    = 1'b0;
      mdu_done_raw = 1'b0;
      mdu_busy_raw = (state == BUSY);
      case (state)
         IDLE: mdu_stall = mdu_op_e;
         BUSY: begin
            mdu_stall    = (cnt != 4'd0);
            mdu_done_raw = (cnt == 4'd0);
         end
         default: ;
      endcase
   end

   // Pipeline control outputs, all quiet while reset is held
   always_comb begin
      forward_a_e = 2'b00;
      forward_b_e = 2'b00;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      flush_m     = 1'b0;
      mdu_busy    = 1'b0;
      mdu_done    = 1'b0;
      if (!rst) begin
         forward_a_e = fwd_a;
         forward_b_e = fwd_b;
         stall_f     = lw_stall | mdu_stall;
         stall_d     = lw_stall | mdu_stall;
         stall_e     = mdu_stall;
         flush_d     = pc_src_e;
         flush_e     = pc_src_e | lw_stall;
         flush_m     = mdu_stall;
         mdu_busy    = mdu_busy_raw;
         mdu_done    = mdu_done_raw;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the combinational
// paths plus hand sequences for MDU timing, counter saturation and reset.
`timescale 1ns/1ps
module tb_hazard_ctrl;

   localparam int CW = 4;   // narrow counters so saturation is reachable

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0]    res_src_e;
   logic          mdu_op_e, pc_src_e, reg_write_m, reg_write_w;
   logic [1:0]    forward_a_e, forward_b_e;
   logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
   logic          mdu_busy, mdu_done;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.MDU_LATENCY(4), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .res_src_e(res_src_e), .mdu_op_e(mdu_op_e), .pc_src_e(pc_src_e),
      .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
   typedef struct {
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic [1:0] res_src;
      logic       pc_src;
      logic [4:0] rd_m;
      logic       rwm;
      logic [4:0] rd_w;
      logic       rww;
      logic [1:0] fa, fb;
      logic [5:0] ctl;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   int n_cmp = 0;
   int n_err = 0;
   int exp_sc = 0;
   int exp_fc = 0;

   function automatic int sat_inc(input int v);
      return (v == (1 << CW) - 1) ? v : v + 1;
   endfunction

   function automatic logic [5:0] ctl_now();
      return {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      res_src_e = 2'b00; mdu_op_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
   endtask

   // advance to just after the next rising edge; inputs are driven here
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] stall_pat, busy_pat, done_pat;

   initial begin
      //                 rs1_d rs2_d rs1_e rs2_e rd_e res  pc   rd_m rwm  rd_w rww  fa     fb     ctl
      vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b01, 2'b00, 6'b000000};
      vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b10, 2'b00, 6'b000000};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00, 6'b000000};
      vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 2'b00, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 2'b01, 2'b10, 6'b000000};
      vecs[4]  = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 2'b00, 1'b0, 5'd6, 1'b0, 5'd6, 1'b0, 2'b00, 2'b00, 6'b000000};
      vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b110010};
      vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000000};
      vecs[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000000};
      vecs[8]  = '{5'd4, 5'd1, 5'd0, 5'd0, 5'd4, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b110010};
      vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000110};
      vecs[10] = '{5'd2, 5'd0, 5'd2, 5'd0, 5'd2, 2'b01, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 2'b10, 2'b00, 6'b110110};
      vecs[11] = '{5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 6'b000000};

      // reset forces every output quiet even with hazards on the inputs
      rst = 1'b1;
      idle_inputs();
      rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; pc_src_e = 1'b1;
      mdu_op_e = 1'b1; res_src_e = 2'b01; rd_e = 5'd7; rs1_d = 5'd7;
      #3;
      chk("rst_fwd_a", forward_a_e, 0);
      chk("rst_ctl", ctl_now(), 0);
      chk("rst_busy_done", {mdu_busy, mdu_done}, 0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
      @(posedge clk);
      #2;
      chk("rst_hold_busy", mdu_busy, 0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;

      // table-driven combinational checks, one vector per cycle
      for (int i = 0; i < NV; i++) begin
         next_cycle();
         rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
         rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e; rd_e = vecs[i].rd_e;
         res_src_e = vecs[i].res_src; pc_src_e = vecs[i].pc_src;
         rd_m = vecs[i].rd_m; reg_write_m = vecs[i].rwm;
         rd_w = vecs[i].rd_w; reg_write_w = vecs[i].rww;
         #2;
         chk($sformatf("v%0d_fwd_a", i), forward_a_e, vecs[i].fa);
         chk($sformatf("v%0d_fwd_b", i), forward_b_e, vecs[i].fb);
         chk($sformatf("v%0d_ctl", i), ctl_now(), vecs[i].ctl);
         if (vecs[i].ctl[5]) exp_sc = sat_inc(exp_sc);
         if (vecs[i].ctl[2]) exp_fc = sat_inc(exp_fc);
      end
      next_cycle();
      idle_inputs();
      #2;
      chk("tbl_stall_cnt", stall_cnt, exp_sc);
      chk("tbl_flush_cnt", flush_cnt, exp_fc);

      // back-to-back MDU ops: mdu_op_e held for cycles 0..7
      stall_pat = 8'b0111_0111;
      busy_pat  = 8'b1110_1110;
      done_pat  = 8'b1000_1000;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         mdu_op_e = 1'b1;
         #2;
         chk($sformatf("mdu_c%0d_ctl", c), ctl_now(),
             stall_pat[c] ? 6'b111001 : 6'b000000);
         chk($sformatf("mdu_c%0d_busy", c), mdu_busy, busy_pat[c]);
         chk($sformatf("mdu_c%0d_done", c), mdu_done, done_pat[c]);
         if (c == 4) chk("mdu_stall_cnt", stall_cnt, exp_sc);
         if (stall_pat[c]) exp_sc = sat_inc(exp_sc);
      end
      next_cycle();
      mdu_op_e = 1'b0;
      #2;
      chk("mdu_idle_ctl", ctl_now(), 0);
      chk("mdu_idle_busy", mdu_busy, 0);
      chk("mdu_end_stall_cnt", stall_cnt, exp_sc);

      // single branch, then hold it to saturate the flush counter
      next_cycle();
      pc_src_e = 1'b1;
      #2;
      chk("br_ctl", ctl_now(), 6'b000110);
      exp_fc = sat_inc(exp_fc);
      next_cycle();
      pc_src_e = 1'b0;
      #2;
      chk("br_flush_cnt", flush_cnt, exp_fc);
      for (int c = 0; c < 16; c++) begin
         next_cycle();
         pc_src_e = 1'b1;
         res_src_e = 2'b01; rd_e = 5'd9; rs2_d = 5'd9;   // load-use alongside
         exp_fc = sat_inc(exp_fc);
         exp_sc = sat_inc(exp_sc);
      end
      next_cycle();
      idle_inputs();
      #2;
      chk("sat_flush_cnt", flush_cnt, (1 << CW) - 1);
      chk("sat_stall_cnt", stall_cnt, (1 << CW) - 1);
      chk("sat_model_cnt", {stall_cnt, flush_cnt}, {exp_sc[CW-1:0], exp_fc[CW-1:0]});

      // asynchronous reset during BUSY
      next_cycle();
      mdu_op_e = 1'b1;      // cycle 0
      next_cycle();         // cycle 1
      next_cycle();         // cycle 2
      #2;
      chk("midrst_pre_busy", mdu_busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", mdu_busy, 0);
      chk("midrst_ctl", ctl_now(), 0);
      chk("midrst_cnts", {stall_cnt, flush_cnt}, 0);
      mdu_op_e = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         #2;
         chk($sformatf("post_rst_c%0d_busy", c), {mdu_busy, mdu_done}, 0);
         chk($sformatf("post_rst_c%0d_ctl", c), ctl_now(), 0);
      end
      chk("post_rst_stall_cnt", stall_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // guard against a stuck run
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule
